// File: rtl/if_id_stage_if.sv
// rtl/if_id_stage_if.sv - instruction memory fetch bus between the fetch stage and imem
//
// Purpose: bundles the instruction-memory request/response signals.
// Signals:
//   imem_req   - fetch request this cycle (stage -> memory)
//   imem_addr  - fetch address, word aligned (stage -> memory)
//   imem_rdata - instruction word, valid one cycle after an accepted request (memory -> stage)
// Modports: master = fetch stage side, slave = instruction memory side.

interface if_id_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata
   );
endinterface

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - instruction fetch stage with IF/ID pipeline register
//
// Purpose: generates the PC, fetches from a one-cycle-latency instruction
// memory, and presents the fetched instruction to decode. Stalls freeze the
// PC and IF/ID; an instruction returning from memory during a stall is parked
// in a hold buffer so nothing is lost or duplicated. Flush redirects the PC.
// Ports:
//   clk          - clock, rising edge
//   reset_n      - synchronous reset, active high (1 = reset)
//   stall        - freeze PC and IF/ID
//   flush        - redirect to redirect_pc (priority over stall)
//   redirect_pc  - redirect target, low two bits ignored
//   imem         - fetch bus (master side)
//   ins_ifid     - IF/ID instruction (NOP_INS when not valid)
//   pc_ifid      - PC of ins_ifid
//   valid_ifid   - ins_ifid is a real fetched instruction
//   opcode_ifid, func3_ifid, func7_ifid - decoded fields of ins_ifid

module if_id_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 stall,
   input  logic                 flush,
   input  logic [31:0]          redirect_pc,
   if_id_stage_if.master        imem,
   output logic [31:0]          ins_ifid,
   output logic [31:0]          pc_ifid,
   output logic                 valid_ifid,
   output logic [6:0]           opcode_ifid,
   output logic [2:0]           func3_ifid,
   output logic                 func7_ifid
);

   logic [31:0] pc;
   logic        inflight_valid;
   logic [31:0] inflight_pc;
   logic        hold_valid;
   logic [31:0] hold_ins;
   logic [31:0] hold_pc;

   assign imem.imem_req  = ~reset_n & ~flush & ~stall;
   assign imem.imem_addr = pc;

   assign opcode_ifid = ins_ifid[6:0];
   assign func3_ifid  = ins_ifid[14:12];
   assign func7_ifid  = ins_ifid[30];

   always_ff @(posedge clk) begin
      if (reset_n) begin
         pc             <= RESET_PC;
         inflight_valid <= 1'b0;
         inflight_pc    <= 32'h0;
         hold_valid     <= 1'b0;
         hold_ins       <= NOP_INS;
         hold_pc        <= 32'h0;
         ins_ifid       <= NOP_INS;
         pc_ifid        <= 32'h0;
         valid_ifid     <= 1'b0;
      end else if (flush) begin
         // Whatever is in flight or held belongs to the wrong path.
         pc             <= redirect_pc & 32'hFFFF_FFFC;
         inflight_valid <= 1'b0;
         hold_valid     <= 1'b0;
         valid_ifid     <= 1'b0;
         ins_ifid       <= NOP_INS;
      end else if (stall) begin
         // No request goes out this cycle, so at most one word can arrive
         // during a stall; park it until decode moves again.
         if (inflight_valid) begin
            hold_valid <= 1'b1;
            hold_ins   <= imem.imem_rdata;
            hold_pc    <= inflight_pc;
         end
         inflight_valid <= 1'b0;
      end else begin
         pc             <= pc + 32'd4;
         inflight_valid <= 1'b1;
         inflight_pc    <= pc;
         hold_valid     <= 1'b0;
         // A held word is older than anything in flight, and a held word
         // implies nothing is in flight (cleared during the stall).
         if (hold_valid) begin
            ins_ifid   <= hold_ins;
            pc_ifid    <= hold_pc;
            valid_ifid <= 1'b1;
         end else begin
            ins_ifid   <= inflight_valid ? imem.imem_rdata : NOP_INS;
            pc_ifid    <= inflight_pc;
            valid_ifid <= inflight_valid;
         end
      end
   end

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - self-checking bench for if_id_stage

module tb_if_id_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        reset_n;
   logic        stall;
   logic        flush;
   logic [31:0] redirect_pc;
   logic [31:0] ins_ifid;
   logic [31:0] pc_ifid;
   logic        valid_ifid;
   logic [6:0]  opcode_ifid;
   logic [2:0]  func3_ifid;
   logic        func7_ifid;

   int checks;
   int failures;

   if_id_stage_if bus ();

   if_id_stage dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .stall       (stall),
      .flush       (flush),
      .redirect_pc (redirect_pc),
      .imem        (bus.master),
      .ins_ifid    (ins_ifid),
      .pc_ifid     (pc_ifid),
      .valid_ifid  (valid_ifid),
      .opcode_ifid (opcode_ifid),
      .func3_ifid  (func3_ifid),
      .func7_ifid  (func7_ifid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a ^ 32'h4A5A_5000) | 32'h3;
   endfunction

   // Instruction memory: one-cycle latency, garbage when not requested.
   always @(posedge clk) begin
      if (bus.imem_req) bus.imem_rdata <= word_of(bus.imem_addr);
      else              bus.imem_rdata <= 32'hDEAD_BEEF;
   end

   typedef struct {
      logic        rst;
      logic        stl;
      logic        fl;
      logic [31:0] rpc;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_v;
      logic        chk_pc;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic rst, input logic stl, input logic fl,
                               input logic [31:0] rpc, input logic e_req,
                               input logic [31:0] e_addr, input logic e_v,
                               input logic chk_pc, input logic [31:0] e_pc);
      vec_t v;
      v.rst = rst; v.stl = stl; v.fl = fl; v.rpc = rpc;
      v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v;
      v.chk_pc = chk_pc; v.e_pc = e_pc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic stl, input logic fl, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      reset_n     = rst;
      stall       = stl;
      flush       = fl;
      redirect_pc = rpc;
      #1;
   endtask

   logic [31:0] exp_ins;
   logic [31:0] next_pc;
   int          delivered;
   logic        r_stall;

   initial begin
      checks = 0;
      failures = 0;
      reset_n = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      redirect_pc = 32'h0;
      repeat (2) @(posedge clk);

      //            rst stl fl  rpc            req addr           v   cpc pc
      vq.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,          0,  1, 32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0,          0,  0, 32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h4,          0,  0, 32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h8,          1,  0, 32'h0));
      vq.push_back(mk(0, 1, 0, 32'h0,          0, 32'hC,          1,  0, 32'h4));
      vq.push_back(mk(0, 1, 0, 32'h0,          0, 32'hC,          1,  0, 32'h4));
      vq.push_back(mk(0, 1, 0, 32'h0,          0, 32'hC,          1,  0, 32'h4));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'hC,          1,  0, 32'h4));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h10,         1,  0, 32'h8));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h14,         1,  0, 32'hC));
      vq.push_back(mk(0, 1, 0, 32'h0,          0, 32'h18,         1,  0, 32'h10));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h18,         1,  0, 32'h10));
      vq.push_back(mk(0, 1, 0, 32'h0,          0, 32'h1C,         1,  0, 32'h14));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h1C,         1,  0, 32'h14));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h20,         1,  0, 32'h18));
      vq.push_back(mk(0, 0, 1, 32'h102,        0, 32'h24,         1,  0, 32'h1C));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h100,        0,  0, 32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h104,        0,  0, 32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h108,        1,  0, 32'h100));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h10C,        1,  0, 32'h104));
      vq.push_back(mk(0, 1, 0, 32'h0,          0, 32'h110,        1,  0, 32'h108));
      vq.push_back(mk(0, 1, 1, 32'h200,        0, 32'h110,        1,  0, 32'h108));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h200,        0,  0, 32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h204,        0,  0, 32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h208,        1,  0, 32'h200));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h20C,        1,  0, 32'h204));
      vq.push_back(mk(0, 0, 1, 32'hFFFF_FFFF,  0, 32'h210,        1,  0, 32'h208));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'hFFFF_FFFC,  0,  0, 32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0,          0,  0, 32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h4,          1,  0, 32'hFFFF_FFFC));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h8,          1,  0, 32'h0));
      vq.push_back(mk(0, 1, 0, 32'h0,          0, 32'hC,          1,  0, 32'h4));
      vq.push_back(mk(1, 1, 1, 32'h300,        0, 32'hC,          1,  0, 32'h4));
      vq.push_back(mk(1, 0, 0, 32'h0,          0, 32'h0,          0,  1, 32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h0,          0,  0, 32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h4,          0,  0, 32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h8,          1,  0, 32'h0));
      vq.push_back(mk(0, 0, 1, 32'h40,         0, 32'hC,          1,  0, 32'h4));
      vq.push_back(mk(0, 1, 1, 32'h80,         0, 32'h40,         0,  0, 32'h0));
      vq.push_back(mk(0, 1, 0, 32'h0,          0, 32'h80,         0,  0, 32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h80,         0,  0, 32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h84,         0,  0, 32'h0));
      vq.push_back(mk(0, 0, 0, 32'h0,          1, 32'h88,         1,  0, 32'h80));

      foreach (vq[i]) begin
         drive(vq[i].rst, vq[i].stl, vq[i].fl, vq[i].rpc);
         exp_ins = vq[i].e_v ? word_of(vq[i].e_pc) : NOP;
         chk($sformatf("v%0d imem_req", i), {31'h0, bus.imem_req}, {31'h0, vq[i].e_req});
         chk($sformatf("v%0d imem_addr", i), bus.imem_addr, vq[i].e_addr);
         chk($sformatf("v%0d valid_ifid", i), {31'h0, valid_ifid}, {31'h0, vq[i].e_v});
         chk($sformatf("v%0d ins_ifid", i), ins_ifid, exp_ins);
         if (vq[i].e_v || vq[i].chk_pc)
            chk($sformatf("v%0d pc_ifid", i), pc_ifid, vq[i].e_pc);
         chk($sformatf("v%0d fields", i), {20'h0, opcode_ifid, func3_ifid, func7_ifid, 1'b0},
             {20'h0, exp_ins[6:0], exp_ins[14:12], exp_ins[30], 1'b0});
      end

      // Random stall stream: every consumed instruction must be the next
      // sequential PC with its own memory word; no gaps, no repeats.
      drive(1, 0, 0, 32'h0);
      next_pc = 32'h0;
      delivered = 0;
      for (int c = 0; c < 300; c++) begin
         r_stall = ($urandom_range(0, 2) == 0);
         drive(0, r_stall, 0, 32'h0);
         chk($sformatf("rs%0d imem_req", c), {31'h0, bus.imem_req}, {31'h0, ~r_stall});
         if (!r_stall && valid_ifid) begin
            chk($sformatf("rs%0d pc_ifid", c), pc_ifid, next_pc);
            chk($sformatf("rs%0d ins_ifid", c), ins_ifid, word_of(next_pc));
            next_pc = next_pc + 32'd4;
            delivered++;
         end
      end
      chk("rs progress", {31'h0, delivered >= 100}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter NOP_INS, default 32'h0000_0013, meaning the instruction presented to decode when the stage is empty or flushed.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-high reset (1 = reset), sampled on the rising edge of clk.
REQ-005 SHALL have port stall  input  1  hazard hold: freeze PC and IF/ID contents.
REQ-006 SHALL have port flush  input  1  branch/jump redirect request.
REQ-007 SHALL have port redirect_pc  input  32  redirect target, sampled when flush=1.
REQ-008 SHALL have port imem_req  output  1  fetch request this cycle.
REQ-009 SHALL have port imem_addr  output  32  fetch address (the PC).
REQ-010 SHALL have port imem_rdata  input  32  instruction word, valid exactly one cycle after the accepted imem_req.
REQ-011 SHALL have port ins_ifid  output  32  IF/ID instruction.
REQ-012 SHALL have port pc_ifid  output  32  PC of ins_ifid.
REQ-013 SHALL have port valid_ifid  output  1  ins_ifid is a real fetched instruction.
REQ-014 SHALL have ports opcode_ifid (output 7) = ins_ifid[6:0], func3_ifid (output 3) = ins_ifid[14:12], func7_ifid (output 1) = ins_ifid[30], all combinational from ins_ifid.

Function
REQ-015 SHALL hold state: pc, in-flight slot (valid, pc), hold buffer (valid, ins, pc), and the IF/ID register (ins, pc, valid).
REQ-016 SHALL drive imem_addr = pc and imem_req = 1 whenever reset_n=0, flush=0 and stall=0; otherwise imem_req = 0.
REQ-017 Normal cycle (no flush, no stall): pc <= pc+4; in-flight <= {1, pc}; IF/ID <= hold buffer if hold valid, else {imem_rdata, in-flight pc, in-flight valid}; hold valid <= 0.
REQ-018 SHALL load NOP_INS into ins_ifid whenever the loaded valid bit is 0.
REQ-019 Stall cycle (no flush): pc and IF/ID unchanged; if in-flight valid, hold buffer <= {1, imem_rdata, in-flight pc}; in-flight valid <= 0.
REQ-020 SHALL lose no instruction and duplicate none across any stall length, including stalls of 1 cycle and back-to-back stalls.
REQ-021 Flush cycle: pc <= {redirect_pc[31:2], 2'b00}; in-flight valid, hold valid and valid_ifid <= 0; ins_ifid <= NOP_INS.
REQ-022 SHALL give flush priority over stall when both are 1 in the same cycle.
REQ-023 Redirect latency: flush in cycle N -> imem_addr = target with imem_req=1 in cycle N+1; valid_ifid=1, pc_ifid=target in cycle N+3 (two bubble cycles).
REQ-024 SHALL wrap PC modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-025 SHALL keep stall/flush with valid_ifid=0 legal: state behaves per REQ-019/021 with no spurious valid.

Reset
REQ-026 SHALL, while reset_n=1 at a rising edge: pc <= RESET_PC; in-flight, hold and IF/ID valid <= 0; ins_ifid <= NOP_INS; pc_ifid <= 0.
REQ-027 SHALL ignore stall and flush while reset_n=1 and drive imem_req=0 during reset cycles.
REQ-028 SHALL apply reset asserted mid-operation identically, discarding any in-flight or held instruction.
REQ-029 SHALL issue the first fetch (imem_addr=RESET_PC, imem_req=1) in the first cycle after reset_n deasserts; valid_ifid=1 with pc_ifid=RESET_PC two cycles later.

Verification
REQ-030 Reset then free-run, imem returns addr-derived words -> pc_ifid sequence 0,4,8,12 on consecutive cycles, valid_ifid=1 from cycle 2 after reset.
REQ-031 Stall for 3 cycles while 0x8 in flight -> ins_ifid/pc_ifid frozen, imem_req=0; after release pc_ifid continues 0x8, 0xC with no gap or repeat.
REQ-032 flush=1 with redirect_pc=32'h0000_0102 -> imem_addr=0x100 next cycle, valid_ifid=0 and ins_ifid=0x13 for two cycles, then pc_ifid=0x100.
REQ-033 flush=1 and stall=1 same cycle -> flush behaviour exactly as REQ-032; held instruction discarded.
REQ-034 reset_n=1 during a stall with hold buffer full -> all valids 0, ins_ifid=0x13, first fetch at RESET_PC after release.
REQ-035 pc forced to 32'hFFFF_FFFC by redirect -> next fetch address 32'h0000_0000.
